// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment readback slice: segment patterns
// (bit0=a .. bit6=g, bit7=dp), BCD digit type, receiver states and a
// 4-digit BCD increment helper used by the optional sequence check.
package seg7_pkg;

   localparam logic [7:0] SEG_0 = 8'h3F;
   localparam logic [7:0] SEG_1 = 8'h06;
   localparam logic [7:0] SEG_2 = 8'h5B;
   localparam logic [7:0] SEG_3 = 8'h4F;
   localparam logic [7:0] SEG_4 = 8'h66;
   localparam logic [7:0] SEG_5 = 8'h6D;
   localparam logic [7:0] SEG_6 = 8'h7D;
   localparam logic [7:0] SEG_7 = 8'h07;
   localparam logic [7:0] SEG_8 = 8'h7F;
   localparam logic [7:0] SEG_9 = 8'h6F;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      STABLE = 2'd1,
      ERROR  = 2'd2
   } state_t;

   // 16-bit packed BCD plus one; 9999 wraps to 0000.
   function automatic logic [15:0] bcd_inc4(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry == 1'b1) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Single-digit seven-segment decoder: exact match of segments a..g against
// the ten digit patterns; the decimal point is ignored. Anything else,
// including a blank digit, is reported as invalid.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [7:0] seg,
   output logic       valid,
   output bcd_t       digit
);

   logic [7:0] seg_m;
   logic       dp_unused;

   assign seg_m     = {1'b0, seg[6:0]};
   assign dp_unused = seg[7];

   // Pattern lookup; unmatched patterns flag invalid and return digit 0.
   always_comb begin
      valid = 1'b1;
      digit = 4'd0;
      case (seg_m)
         SEG_0:   digit = 4'd0;
         SEG_1:   digit = 4'd1;
         SEG_2:   digit = 4'd2;
         SEG_3:   digit = 4'd3;
         SEG_4:   digit = 4'd4;
         SEG_5:   digit = 4'd5;
         SEG_6:   digit = 4'd6;
         SEG_7:   digit = 4'd7;
         SEG_8:   digit = 4'd8;
         SEG_9:   digit = 4'd9;
         default: begin
            valid = 1'b0;
            digit = 4'd0;
         end
      endcase
   end

endmodule

// File: rtl/seg7_readback.sv
// Seven-segment display bus receiver: samples four digit patterns, waits for
// them to hold still, decodes to BCD and offers each new stable value over a
// VALID/READY handshake. Non-digit patterns are reported on BAD_PATTERN /
// BAD_DIGIT. Optional build macro SEG7_SEQ_CHECK_EN adds SEQ_ERR, a one-cycle
// flag on any capture that is neither last+1 (BCD, with wrap) nor 0000.
module seg7_readback
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 3
)(
   input  logic        TIMER,
   input  logic        BUTTON,
   input  logic [7:0]  A0,
   input  logic [7:0]  A1,
   input  logic [7:0]  A2,
   input  logic [7:0]  A3,
   output logic [15:0] VALUE,
   output logic        VALID,
   input  logic        READY,
   output logic        BAD_PATTERN,
   output logic [1:0]  BAD_DIGIT,
   output logic        SEQ_ERR
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic [27:0]      a_masked;
   logic             dp_unused;
   logic [27:0]      s_d, s_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   state_t           state_d, state_q;
   logic [15:0]      value_d, value_q;
   logic             valid_d, valid_q;
   logic             has_last_d, has_last_q;
   logic             bad_pattern_d, bad_pattern_q;
   logic [1:0]       bad_digit_d, bad_digit_q;
   logic [3:0]       dig_valid;
   logic [15:0]      decoded;
   logic             all_valid;
   logic             changed;
   logic             capture;
   logic [1:0]       lowest_bad;

   // Decimal points never take part in comparison or decoding.
   assign a_masked  = {A3[6:0], A2[6:0], A1[6:0], A0[6:0]};
   assign dp_unused = ^{A3[7], A2[7], A1[7], A0[7]};
   assign changed   = (a_masked != s_q);
   assign all_valid = &dig_valid;

   // Decode the held sample, not the live inputs, so decode matches what was compared.
   for (genvar g = 0; g < 4; g++) begin : g_dec
      seg7_decode u_dec (
         .seg   ({1'b0, s_q[g*7 +: 7]}),
         .valid (dig_valid[g]),
         .digit (decoded[g*4 +: 4])
      );
   end

   // Priority pick of the lowest-numbered digit that failed to decode.
   always_comb begin
      lowest_bad = 2'd0;
      if (!dig_valid[0]) begin
         lowest_bad = 2'd0;
      end else if (!dig_valid[1]) begin
         lowest_bad = 2'd1;
      end else if (!dig_valid[2]) begin
         lowest_bad = 2'd2;
      end else begin
         lowest_bad = 2'd3;
      end
   end

   // Stability tracking, state transitions, capture and handshake for this edge.
   always_comb begin
      s_d           = a_masked;
      cnt_d         = cnt_q;
      state_d       = state_q;
      value_d       = value_q;
      valid_d       = valid_q;
      has_last_d    = has_last_q;
      bad_pattern_d = 1'b0;
      bad_digit_d   = 2'd0;
      capture       = 1'b0;

      if (changed) begin
         cnt_d = CNT_ZERO;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end

      case (state_q)
         SETTLE: begin
            if (!changed && (cnt_q == CNT_MAX)) begin
               if (all_valid) begin
                  state_d = STABLE;
               end else begin
                  state_d = ERROR;
               end
            end else begin
               state_d = SETTLE;
            end
         end
         STABLE, ERROR: begin
            if (changed) begin
               state_d = SETTLE;
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = SETTLE;
      endcase

      // Capture on the edge that enters STABLE as well as any later edge that
      // stays there, so a capture held off by a full slot is only deferred.
      capture = (state_d == STABLE)
              && (!has_last_q || (decoded != value_q))
              && (!valid_q || READY);

      if (capture) begin
         value_d    = decoded;
         valid_d    = 1'b1;
         has_last_d = 1'b1;
      end else if (valid_q && READY) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      if (state_d == ERROR) begin
         bad_pattern_d = 1'b1;
         bad_digit_d   = lowest_bad;
      end else begin
         bad_pattern_d = 1'b0;
         bad_digit_d   = 2'd0;
      end
   end

   // Receiver registers; reset drops any pending capture and forgets the last value.
   always_ff @(posedge TIMER or negedge BUTTON) begin
      if (!BUTTON) begin
         s_q           <= 28'd0;
         cnt_q         <= CNT_ZERO;
         state_q       <= SETTLE;
         value_q       <= 16'd0;
         valid_q       <= 1'b0;
         has_last_q    <= 1'b0;
         bad_pattern_q <= 1'b0;
         bad_digit_q   <= 2'd0;
      end else begin
         s_q           <= s_d;
         cnt_q         <= cnt_d;
         state_q       <= state_d;
         value_q       <= value_d;
         valid_q       <= valid_d;
         has_last_q    <= has_last_d;
         bad_pattern_q <= bad_pattern_d;
         bad_digit_q   <= bad_digit_d;
      end
   end

   assign VALUE       = value_q;
   assign VALID       = valid_q;
   assign BAD_PATTERN = bad_pattern_q;
   assign BAD_DIGIT   = bad_digit_q;

`ifdef SEG7_SEQ_CHECK_EN
   logic seq_err_d, seq_err_q;

   // Flag a capture that neither continues the count nor restarts it at zero.
   always_comb begin
      seq_err_d = 1'b0;
      if (capture && has_last_q
          && (decoded != bcd_inc4(value_q)) && (decoded != 16'h0000)) begin
         seq_err_d = 1'b1;
      end else begin
         seq_err_d = 1'b0;
      end
   end

   // One-cycle sequence-error register, aligned with VALID rising.
   always_ff @(posedge TIMER or negedge BUTTON) begin
      if (!BUTTON) begin
         seq_err_q <= 1'b0;
      end else begin
         seq_err_q <= seq_err_d;
      end
   end

   assign SEQ_ERR = seq_err_q;
`else
   assign SEQ_ERR = 1'b0;
`endif

endmodule
